uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 36 +++
 rtl/uart_rx.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle for uart_rx: byte/valid/ready plus error pulses.
// UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun_err;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun_err
`ifdef UART_RX_PARITY_EN
        , output parity_err
`endif
    );

    modport slave (
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun_err
`ifdef UART_RX_PARITY_EN
        , input  parity_err
`endif
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready output, frame and overrun detection.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err pulse.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       rx,
    uart_rx_if.master  bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_ZERO = BW'(1'b0);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1'b1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        even_parity = ^d;
    endfunction
`else
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

    state_t               state_r, state_nx;
    logic [CW-1:0]        cnt_r, cnt_nx;
    logic [BW-1:0]        bit_r, bit_nx;
    logic [DATA_BITS-1:0] shift_r, shift_nx;
    logic [DATA_BITS-1:0] data_r, data_nx;
    logic                 valid_r, valid_nx;
    logic                 ferr_r, ferr_nx;
    logic                 oerr_r, oerr_nx;
    logic                 frame_ok_s;
    logic                 rx_meta_r, rx_sync_r, rx_prev_r;
    logic                 rx_s, fall_s;
`ifdef UART_RX_PARITY_EN
    logic                 pbad_r, pbad_nx;
    logic                 perr_r, perr_nx;
`endif

    assign rx_s   = rx_sync_r;
    // Edge detector runs every clk so a start edge is seen even between baud ticks.
    assign fall_s = rx_prev_r & ~rx_s;

    // Two-flop synchronizer plus previous-sample register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= BIT_ZERO;
            shift_r <= {DATA_BITS{1'b0}};
            data_r  <= {DATA_BITS{1'b0}};
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            oerr_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_r  <= 1'b0;
            perr_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            bit_r   <= bit_nx;
            shift_r <= shift_nx;
            data_r  <= data_nx;
            valid_r <= valid_nx;
            ferr_r  <= ferr_nx;
            oerr_r  <= oerr_nx;
`ifdef UART_RX_PARITY_EN
            pbad_r  <= pbad_nx;
            perr_r  <= perr_nx;
`endif
        end
    end

    // Next-state, sampling and output-update logic.
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        bit_nx     = bit_r;
        shift_nx   = shift_r;
        data_nx    = data_r;
        ferr_nx    = 1'b0;
        oerr_nx    = 1'b0;
        frame_ok_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_nx    = pbad_r;
        perr_nx    = 1'b0;
`endif
        if (valid_r && bus.rx_ready) begin
            valid_nx = 1'b0;
        end else begin
            valid_nx = valid_r;
        end

        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_nx = START;
                    cnt_nx   = CNT_ZERO;
                end else begin
                    state_nx = IDLE;
                end
            end
            START: begin
                if (baud_tick && (cnt_r == CNT_MID)) begin
                    cnt_nx = CNT_ZERO;
                    bit_nx = BIT_ZERO;
                    if (rx_s) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = DATA;
                    end
                end else if (baud_tick) begin
                    cnt_nx = cnt_r + CNT_ONE;
                end else begin
                    cnt_nx = cnt_r;
                end
            end
            DATA: begin
                if (baud_tick && (cnt_r == CNT_LAST)) begin
                    cnt_nx   = CNT_ZERO;
                    shift_nx = {rx_s, shift_r[DATA_BITS-1:1]};
                    if (bit_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        bit_nx = bit_r + BIT_ONE;
                    end
                end else if (baud_tick) begin
                    cnt_nx = cnt_r + CNT_ONE;
                end else begin
                    cnt_nx = cnt_r;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_tick && (cnt_r == CNT_LAST)) begin
                    cnt_nx   = CNT_ZERO;
                    pbad_nx  = (rx_s != even_parity(shift_r));
                    state_nx = STOP;
                end else if (baud_tick) begin
                    cnt_nx = cnt_r + CNT_ONE;
                end else begin
                    cnt_nx = cnt_r;
                end
            end
`endif
            STOP: begin
                if (baud_tick && (cnt_r == CNT_LAST)) begin
                    state_nx = IDLE;
                    cnt_nx   = CNT_ZERO;
                    ferr_nx  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                    perr_nx    = pbad_r;
                    frame_ok_s = rx_s & ~pbad_r;
`else
                    frame_ok_s = rx_s;
`endif
                    // A simultaneous consume frees the holding register for the new byte.
                    if (frame_ok_s && valid_r && !bus.rx_ready) begin
                        oerr_nx = 1'b1;
                    end else if (frame_ok_s) begin
                        data_nx  = shift_r;
                        valid_nx = 1'b1;
                    end else begin
                        data_nx = data_r;
                    end
                end else if (baud_tick) begin
                    cnt_nx = cnt_r + CNT_ONE;
                end else begin
                    cnt_nx = cnt_r;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = CNT_ZERO;
            end
        endcase
    end

    assign bus.rx_data     = data_r;
    assign bus.rx_valid    = valid_r;
    assign bus.frame_err   = ferr_r;
    assign bus.overrun_err = oerr_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err  = perr_r;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx; frames are driven in baud-tick units
// and outcomes predicted from frame contents by a small byte-level model.
module tb_uart_rx;
    localparam int OS   = 16;
    localparam int DB   = 8;
    localparam int TICK = 40;
    localparam int BITT = OS * TICK;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk, rst_n, baud_tick, rx;
    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_tick(baud_tick),
        .rx       (rx),
        .bus      (bus)
    );

    int n_vec = 0, n_bad = 0;
    int ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
    int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
    logic [DB-1:0] exp_data;
    logic          exp_valid;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One tick every 4 clocks, present at posedges where time mod 40 == 15.
    initial begin
        baud_tick = 1'b0;
        #12;
        forever begin
            baud_tick = 1'b1;
            #10;
            baud_tick = 1'b0;
            #30;
        end
    end

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (bus.overrun_err === 1'b1) ovr_cnt <= ovr_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (bus.parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
`endif
    end

    function automatic logic even_bit(input logic [DB-1:0] d);
        even_bit = (($countones(d) % 2) == 1);
    endfunction

    task automatic check_counts(input string tag);
        n_vec++;
        if (ferr_cnt !== exp_ferr) begin
            n_bad++;
            $display("FAIL %s frame_err pulses: got %0d expected %0d", tag, ferr_cnt, exp_ferr);
        end
        n_vec++;
        if (ovr_cnt !== exp_ovr) begin
            n_bad++;
            $display("FAIL %s overrun_err pulses: got %0d expected %0d", tag, ovr_cnt, exp_ovr);
        end
        n_vec++;
        if (perr_cnt !== exp_perr) begin
            n_bad++;
            $display("FAIL %s parity_err pulses: got %0d expected %0d", tag, perr_cnt, exp_perr);
        end
    endtask

    // Drives one full frame; rdy raises rx_ready only in the stop-sample cycle.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par, input logic rdy);
        longint t0, p3, dl, ts;
        logic   par_ok, good;
        @(negedge clk);
        t0 = $time;
        rx = 1'b0;
        p3 = t0 + 25;
        dl = (15 - (p3 % 40) + 40) % 40;
        if (dl == 0) dl = 40;
        ts = p3 + dl + TICK * (OS / 2 - 1) + BITT * (DB + 1 + PB);
        #(BITT);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            #(BITT);
        end
        if (PB == 1) begin
            rx = par;
            #(BITT);
        end
        rx = stop;
        #(ts - 5 - $time);
        n_vec++;
        if (bus.rx_valid !== exp_valid) begin
            n_bad++;
            $display("FAIL pre_valid byte %02h: got %0b expected %0b", d, bus.rx_valid, exp_valid);
        end
        n_vec++;
        if (bus.rx_data !== exp_data) begin
            n_bad++;
            $display("FAIL pre_data byte %02h: got %02h expected %02h", d, bus.rx_data, exp_data);
        end
        bus.rx_ready = rdy;
        #10;
        bus.rx_ready = 1'b0;
        par_ok = (PB == 0) || (par == even_bit(d));
        good   = stop && par_ok;
        if (!stop) exp_ferr++;
        if (!par_ok) exp_perr++;
        if (good && exp_valid && !rdy) begin
            exp_ovr++;
        end else if (good) begin
            exp_data  = d;
            exp_valid = 1'b1;
        end else if (rdy) begin
            exp_valid = 1'b0;
        end
        n_vec++;
        if (bus.rx_valid !== exp_valid) begin
            n_bad++;
            $display("FAIL post_valid byte %02h: got %0b expected %0b", d, bus.rx_valid, exp_valid);
        end
        n_vec++;
        if (bus.rx_data !== exp_data) begin
            n_bad++;
            $display("FAIL post_data byte %02h: got %02h expected %02h", d, bus.rx_data, exp_data);
        end
        #(t0 + BITT * (DB + 2 + PB) - $time);
        #3;
        check_counts("frame");
    endtask

    task automatic consume();
        @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        exp_valid = 1'b0;
        #1;
        n_vec++;
        if (bus.rx_valid !== exp_valid) begin
            n_bad++;
            $display("FAIL consume valid: got %0b expected %0b", bus.rx_valid, exp_valid);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        n_vec++;
        if (bus.rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s rx_valid: got %0b expected 0", tag, bus.rx_valid);
        end
        n_vec++;
        if (bus.rx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL %s rx_data: got %02h expected 00", tag, bus.rx_data);
        end
        n_vec++;
        if ((bus.frame_err !== 1'b0) || (bus.overrun_err !== 1'b0)) begin
            n_bad++;
            $display("FAIL %s err flags: got %0b%0b expected 00", tag, bus.frame_err, bus.overrun_err);
        end
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #3;
        check_zero_outputs("reset_asserted");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check_zero_outputs("reset_released");
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, even_bit(8'hA5), 1'b0);
        consume();
    endtask

    task automatic test_false_start();
        logic [DB-1:0] d;
        @(negedge clk);
        rx = 1'b0;
        #(6 * TICK);
        rx = 1'b1;
        #(20 * TICK);
        #3;
        n_vec++;
        if (bus.rx_valid !== exp_valid) begin
            n_bad++;
            $display("FAIL false_start valid: got %0b expected %0b", bus.rx_valid, exp_valid);
        end
        check_counts("false_start");
        d = DB'($urandom);
        send_frame(d, 1'b1, even_bit(d), 1'b0);
        consume();
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, even_bit(8'h3C), 1'b0);
        #(3 * BITT);
        n_vec++;
        if (bus.rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL held_low valid: got %0b expected 0", bus.rx_valid);
        end
        check_counts("held_low");
        rx = 1'b1;
        #(BITT);
        check_counts("line_restored");
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, even_bit(8'h11), 1'b0);
        send_frame(8'h22, 1'b1, even_bit(8'h22), 1'b0);
        consume();
        send_frame(8'h11, 1'b1, even_bit(8'h11), 1'b0);
        send_frame(8'h22, 1'b1, even_bit(8'h22), 1'b1);
        consume();
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h33, 1'b1, even_bit(8'h33), 1'b0);
        @(negedge clk);
        rx = 1'b0;
        #(BITT);
        rx = 1'b1;
        #(3 * BITT + BITT / 2);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset_mid_frame");
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        #(2 * BITT);
        send_frame(8'h5A, 1'b1, even_bit(8'h5A), 1'b0);
        consume();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        consume();
    endtask
`endif

    task automatic test_random();
        logic [DB-1:0] d;
        logic          stop, par, rdy;
        for (int k = 0; k < 10; k++) begin
            d    = DB'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            par  = even_bit(d) ^ ($urandom_range(0, 4) == 0);
            rdy  = 1'($urandom_range(0, 1));
            send_frame(d, stop, par, rdy);
            rx = 1'b1;
            repeat ($urandom_range(3, 40)) @(negedge clk);
            if ($urandom_range(0, 2) == 0) consume();
        end
    endtask

    initial begin
        rx           = 1'b1;
        rst_n        = 1'b1;
        bus.rx_ready = 1'b0;
        exp_valid    = 1'b0;
        exp_data     = 8'h00;
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
